// File: rtl/ext_bus_arbiter.sv
// rtl/ext_bus_arbiter.sv - registered round-robin arbiter for the icache/dcache external memory bus
// Grants are locked for a whole transaction and released through one idle RELEASE cycle.
module ext_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 512,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_addr_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_data_ready,
  output logic              i_err,
  input  logic              d_addr_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_write_data_valid,
  input  logic [LINE_W-1:0] d_write_data,
  output logic              d_data_ready,
  output logic              d_err,
  output logic              mem_addr_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_data_valid,
  output logic [LINE_W-1:0] mem_write_data,
  input  logic              mem_data_ready,
  input  logic [LINE_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

  localparam bit              TO_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] LIMIT = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           state;
  logic             last_d;
  logic [CNT_W-1:0] count;
  logic             granted;
  logic             timed_out;

  assign granted   = (state == GRANT_I) || (state == GRANT_D);
  // Completion beats a coincident timeout, hence the mem_data_ready term.
  assign timed_out = TO_EN && granted && (count == LIMIT) && !mem_data_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b1;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (i_addr_valid && (!d_addr_valid || last_d)) begin
            state  <= GRANT_I;
            last_d <= 1'b0;
          end else if (d_addr_valid) begin
            state  <= GRANT_D;
            last_d <= 1'b1;
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem_data_ready || timed_out) begin
            state <= RELEASE;
            count <= '0;
          end else if (TO_EN && (count != LIMIT)) begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign mem_addr_valid       = granted;
  assign mem_addr             = (state == GRANT_I) ? i_addr :
                                (state == GRANT_D) ? d_addr : '0;
  assign mem_write_data_valid = (state == GRANT_D) && d_write_data_valid;
  assign mem_write_data       = (state == GRANT_D) ? d_write_data : '0;

  assign i_data_ready = (state == GRANT_I) && mem_data_ready;
  assign d_data_ready = (state == GRANT_D) && mem_data_ready;
  assign i_err        = (state == GRANT_I) && timed_out;
  assign d_err        = (state == GRANT_D) && timed_out;

  // Read data goes to both caches outside this block; it is not routed here.
  logic unused_read_data;
  assign unused_read_data = ^mem_read_data;

endmodule
